// File: rtl/irq_ctrl.sv
// irq_ctrl: platform interrupt controller with level/edge gateways, priorities and claim/complete
module irq_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3,
  parameter int ID_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               cfg_re,
  input  logic               cfg_we,
  input  logic [11:0]        cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               irq_o
);
  logic [PRIO_W-1:0]  prio_q [NUM_SRC];
  logic [PRIO_W-1:0]  prio_d [NUM_SRC];
  logic [NUM_SRC-1:0] src_q, src_d, pending_q, pending_d, in_flight_q, in_flight_d;
  logic [NUM_SRC-1:0] edge_held_q, edge_held_d, enable_q, enable_d, mode_q, mode_d;
  logic [PRIO_W-1:0]  thr_q, thr_d, best_prio;
  logic [31:0]        rdata_q, rdata_d, rd_val;
  logic               irq_q, irq_d;
  logic [NUM_SRC-1:0] elig, trig, claim_vec, comp_vec, busy;
  logic [ID_W-1:0]    best_id;
  logic [9:0]         word;
  logic               wr, claim, cpl;
  logic               unused_ok;
  assign word      = cfg_addr[11:2];
  assign wr        = cfg_we & ~cfg_re;
  assign claim     = cfg_re & (word == 10'h24);
  assign cpl       = wr & (word == 10'h24);
  assign cfg_rdata = rdata_q;
  assign irq_o     = irq_q;
  assign unused_ok = ^{cfg_addr[1:0], cfg_wdata};
  // eligibility and arbitration: highest priority wins, strict compare keeps the lowest ID on ties
  always_comb begin
    elig      = '0;
    best_id   = '0;
    best_prio = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      elig[k] = pending_q[k] & enable_q[k] & (prio_q[k] > thr_q);
      if (elig[k] && prio_q[k] > best_prio) begin
        best_prio = prio_q[k];
        best_id   = ID_W'(k + 1);
      end
    end
  end
  // gateway, claim/complete and register-write next state; a same-cycle claim counts as in flight
  always_comb begin
    trig      = (mode_q & src_i & ~src_q) | (~mode_q & src_i);
    claim_vec = '0;
    comp_vec  = '0;
    prio_d    = prio_q;
    rd_val    = claim ? 32'(best_id) : word == 10'h20 ? 32'(pending_q) : word == 10'h21 ? 32'(enable_q) :
                word == 10'h22 ? 32'(mode_q) : word == 10'h23 ? 32'(thr_q) : 32'h0;
    for (int k = 0; k < NUM_SRC; k++) begin
      claim_vec[k] = claim && best_id == ID_W'(k + 1);
      comp_vec[k]  = cpl && cfg_wdata[ID_W-1:0] == ID_W'(k + 1) && in_flight_q[k];
      prio_d[k]    = (wr && word == 10'(k + 1)) ? cfg_wdata[PRIO_W-1:0] : prio_q[k];
      rd_val       = (word == 10'(k + 1)) ? 32'(prio_q[k]) : rd_val;
    end
    busy        = in_flight_q | claim_vec;
    pending_d   = (pending_q & ~claim_vec) | (trig & ~busy) | (comp_vec & mode_q & edge_held_q);
    edge_held_d = (edge_held_q & ~(comp_vec & mode_q)) | (trig & mode_q & busy);
    in_flight_d = busy & ~comp_vec;
    enable_d    = (wr && word == 10'h21) ? cfg_wdata[NUM_SRC-1:0] : enable_q;
    mode_d      = (wr && word == 10'h22) ? cfg_wdata[NUM_SRC-1:0] : mode_q;
    thr_d       = (wr && word == 10'h23) ? cfg_wdata[PRIO_W-1:0] : thr_q;
    rdata_d     = cfg_re ? rd_val : rdata_q;
    irq_d       = |elig;
    src_d       = src_i;
  end
  // state registers; reset overrides every same-cycle event
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q      <= '{default: '0};
      src_q       <= '0;
      pending_q   <= '0;
      in_flight_q <= '0;
      edge_held_q <= '0;
      enable_q    <= '0;
      mode_q      <= '0;
      thr_q       <= '0;
      rdata_q     <= '0;
      irq_q       <= 1'b0;
    end else begin
      prio_q      <= prio_d;
      src_q       <= src_d;
      pending_q   <= pending_d;
      in_flight_q <= in_flight_d;
      edge_held_q <= edge_held_d;
      enable_q    <= enable_d;
      mode_q      <= mode_d;
      thr_q       <= thr_d;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
    end
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed tests of irq_ctrl against a per-source behavioural model
module tb_irq_ctrl;
  localparam int N = 8;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] src_i = '0;
  logic         cfg_re = 1'b0, cfg_we = 1'b0;
  logic [11:0]  cfg_addr = '0;
  logic [31:0]  cfg_wdata = '0;
  logic [31:0]  cfg_rdata;
  logic         irq_o;
  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;
  irq_ctrl #(.NUM_SRC(N), .PRIO_W(3), .ID_W(5)) dut (
    .clk(clk), .rst(rst), .src_i(src_i), .cfg_re(cfg_re), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .irq_o(irq_o)
  );
  always #5 clk = ~clk;
  int          m_prio [1:N];
  bit          m_pend [1:N], m_fl [1:N], m_held [1:N], m_prev [1:N], m_en [1:N], m_mode [1:N];
  int          m_thr;
  bit          m_irq;
  logic [31:0] m_rdata;
  function automatic bit elig(int k);
    return m_pend[k] && m_en[k] && m_prio[k] > m_thr;
  endfunction
  function automatic int pick();
    int b = 0, bp = 0;
    for (int k = 1; k <= N; k++) if (elig(k) && m_prio[k] > bp) begin b = k; bp = m_prio[k]; end
    return b;
  endfunction
  function automatic logic [31:0] reg_val(int w);
    logic [31:0] v = 0;
    if (w >= 1 && w <= N) v = m_prio[w];
    else if (w == 35) v = m_thr;
    else for (int k = 1; k <= N; k++)
      v[k-1] = (w == 32) ? m_pend[k] : (w == 33) ? m_en[k] : (w == 34) ? m_mode[k] : 1'b0;
    return v;
  endfunction
  always @(posedge clk) begin : model
    bit tr [1:N];
    bit fl0 [1:N];
    bit md0 [1:N];
    bit any;
    int w, c, id;
    if (rst) begin
      for (int k = 1; k <= N; k++) begin
        m_prio[k] = 0; m_pend[k] = 0; m_fl[k] = 0; m_held[k] = 0; m_prev[k] = 0; m_en[k] = 0; m_mode[k] = 0;
      end
      m_thr = 0; m_irq = 0; m_rdata = 0;
    end else begin
      w = int'(cfg_addr[11:2]);
      any = 0;
      for (int k = 1; k <= N; k++) begin
        any |= elig(k);
        tr[k] = m_mode[k] ? (src_i[k-1] && !m_prev[k]) : src_i[k-1];
      end
      if (cfg_re) begin
        if (w == 36) begin
          c = pick();
          m_rdata = c;
          if (c != 0) begin m_pend[c] = 0; m_fl[c] = 1; end
        end else m_rdata = reg_val(w);
      end
      fl0 = m_fl;
      md0 = m_mode;
      if (cfg_we && !cfg_re) begin
        if (w == 36) begin
          id = int'(cfg_wdata[4:0]);
          if (id >= 1 && id <= N && m_fl[id]) begin
            m_fl[id] = 0;
            if (md0[id] && m_held[id]) begin m_held[id] = 0; m_pend[id] = 1; end
          end
        end else if (w >= 1 && w <= N) m_prio[w] = int'(cfg_wdata[2:0]);
        else if (w == 35) m_thr = int'(cfg_wdata[2:0]);
        else for (int k = 1; k <= N; k++) begin
          if (w == 33) m_en[k] = cfg_wdata[k-1];
          if (w == 34) m_mode[k] = cfg_wdata[k-1];
        end
      end
      for (int k = 1; k <= N; k++) begin
        if (tr[k]) begin
          if (!fl0[k]) m_pend[k] = 1;
          else if (md0[k]) m_held[k] = 1;
        end
        m_prev[k] = src_i[k-1];
      end
      m_irq = any;
    end
  end
  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    check("model irq_o", {31'b0, irq_o}, {31'b0, m_irq});
    check("model cfg_rdata", cfg_rdata, m_rdata);
  end
  task automatic cyc(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic wr(logic [11:0] a, logic [31:0] d);
    cfg_we = 1; cfg_addr = a; cfg_wdata = d; cyc(); cfg_we = 0;
  endtask
  task automatic rd_chk(string nm, logic [11:0] a, logic [31:0] e);
    cfg_re = 1; cfg_addr = a; cyc(); cfg_re = 0;
    check(nm, cfg_rdata, e);
  endtask
  task automatic do_reset();
    rst = 1; src_i = '0; cfg_re = 0; cfg_we = 0; cyc(); chk_en = 1; cyc(); rst = 0;
  endtask
  initial begin
    do_reset();
    for (int k = 1; k <= N; k++) rd_chk("reset prio", 12'(4 * k), 0);
    rd_chk("reset pending", 12'h080, 0);
    rd_chk("reset enable", 12'h084, 0);
    rd_chk("reset mode", 12'h088, 0);
    rd_chk("reset thr", 12'h08C, 0);
    rd_chk("reset claim", 12'h090, 0);
    check("reset irq", {31'b0, irq_o}, 0);
    src_i = '1; cyc(3);
    check("masked irq", {31'b0, irq_o}, 0);
    rd_chk("masked pending", 12'h080, 32'hFF);
    cfg_re = 1; cfg_we = 1; cfg_addr = 12'h084; cfg_wdata = 32'hFF; cyc(); cfg_re = 0; cfg_we = 0;
    rd_chk("dropped write", 12'h084, 0);
    rd_chk("unmapped read", 12'h100, 0);
    do_reset();
    wr(12'h00C, 5); wr(12'h084, 32'h04); wr(12'h08C, 0);
    src_i = 8'h04; cyc();
    check("level n+1 irq", {31'b0, irq_o}, 0);
    cyc();
    check("level n+2 irq", {31'b0, irq_o}, 1);
    rd_chk("level claim", 12'h090, 3);
    cyc();
    check("irq after claim", {31'b0, irq_o}, 0);
    wr(12'h090, 3); cyc();
    rd_chk("level repend", 12'h080, 32'h04);
    check("level irq again", {31'b0, irq_o}, 1);
    do_reset();
    wr(12'h004, 2); wr(12'h008, 4); wr(12'h010, 4); wr(12'h084, 32'h0B);
    src_i = 8'h0B; cyc(2);
    rd_chk("arb claim 1", 12'h090, 2);
    rd_chk("arb claim 2", 12'h090, 4);
    rd_chk("arb claim 3", 12'h090, 1);
    rd_chk("arb claim 4", 12'h090, 0);
    do_reset();
    wr(12'h018, 4); wr(12'h084, 32'h20); wr(12'h08C, 4);
    src_i = 8'h20; cyc(3);
    check("thr4 irq", {31'b0, irq_o}, 0);
    rd_chk("thr4 claim", 12'h090, 0);
    wr(12'h08C, 3); cyc();
    check("thr3 irq", {31'b0, irq_o}, 1);
    rd_chk("thr3 claim", 12'h090, 6);
    wr(12'h090, 7); cyc(2);
    rd_chk("bad complete", 12'h080, 0);
    wr(12'h090, 6); cyc();
    rd_chk("good complete", 12'h080, 32'h20);
    do_reset();
    wr(12'h014, 1); wr(12'h084, 32'h10); wr(12'h088, 32'h10);
    src_i = 8'h10; cyc(); src_i = 0; cyc();
    rd_chk("edge claim", 12'h090, 5);
    src_i = 8'h10; cyc(); src_i = 0; cyc(); src_i = 8'h10; cyc(); src_i = 0; cyc();
    rd_chk("edge held not pending", 12'h080, 0);
    wr(12'h090, 5);
    rd_chk("edge repend", 12'h080, 32'h10);
    rd_chk("edge claim again", 12'h090, 5);
    rd_chk("edge claim empty", 12'h090, 0);
    do_reset();
    wr(12'h008, 1); wr(12'h00C, 1); wr(12'h084, 32'h06);
    src_i = 8'h02; cyc(2);
    rd_chk("mid claim", 12'h090, 2);
    src_i = 8'h06; cyc(2);
    check("mid irq", {31'b0, irq_o}, 1);
    rst = 1; src_i = 0; cyc(); rst = 0;
    check("post reset irq", {31'b0, irq_o}, 0);
    rd_chk("post reset pending", 12'h080, 0);
    rd_chk("post reset claim", 12'h090, 0);
    rd_chk("post reset prio", 12'h008, 0);
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
